product_bcd: RTL and testbench

Sequential signed-binary-to-BCD converter, directly downstream of the 8-bit shift-add multiplier. Captures the 16-bit two's-complement product (multiplier A register in the upper byte, B register in the lower byte) on a start pulse. Converts its magnitude to five packed BCD digits by iterative double-dabble, one bit per clock. Presents sign and digits to the decimal display logic with a one-cycle done pulse.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 25 ++
 rtl/product_bcd.sv | 107 ++++++++++
 tb/tb_product_bcd.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types and constants for the signed binary to BCD converter
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGITS        = 5;
  localparam int SHIFT_COUNT       = 16;
  localparam int BCD_ADJ_THRESHOLD = 5;
  localparam int CNT_W             = 5;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Purpose  : Double-dabble digit correction: add 3 when the digit is >= 5 so
//            that the following left shift carries correctly into the next
//            decimal digit. 4-bit arithmetic, no carry out.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Pre-shift add-3 correction
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'(BCD_ADJ_THRESHOLD)) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/product_bcd.sv
`default_nettype none
// ============================================================================
// Module   : product_bcd
// Purpose  : Sequential signed 16-bit product to sign + 5-digit BCD converter.
//            Latches |Product| on Start, runs one double-dabble step per clock,
//            and publishes Bcd/Neg with a single-cycle Done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module product_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [WIDTH-1:0]          Product,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Neg,
  output logic [BCD_DIGITS*4-1:0]   Bcd
);

  localparam int SCR_W = BCD_DIGITS * 4;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_bin;
  logic [SCR_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;

  logic [WIDTH-1:0]   w_mag;
  logic [SCR_W-1:0]   w_adj;
  logic               w_last_shift;

  // Magnitude of the two's-complement input; 0x8000 maps to 32768 unsigned
  assign w_mag        = Product[WIDTH-1] ? (WIDTH'(0) - Product) : Product;
  assign w_last_shift = (r_cnt == CNT_W'(SHIFT_COUNT - 1));

  // One add-3 corrector per BCD digit of the scratch register
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[gi*4 +: 4]),
      .o_digit (w_adj[gi*4 +: 4])
    );
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start) w_state_nxt = CONV;
      CONV:    if (w_last_shift) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift-add iterations, and registered result outputs.
  // Busy stays high through the cycle in which Done is asserted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Neg       <= 1'b0;
      Bcd       <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: begin
          Busy <= Start;
          if (Start) begin
            r_bin     <= w_mag;
            r_neg     <= Product[WIDTH-1];
            r_scratch <= '0;
            r_cnt     <= '0;
          end
        end
        CONV: begin
          Busy                 <= 1'b1;
          {r_scratch, r_bin}   <= {w_adj, r_bin} << 1;
          r_cnt                <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          Busy <= 1'b1;
          Done <= 1'b1;
          Bcd  <= r_scratch;
          Neg  <= r_neg;
        end
        default: Busy <= 1'b0;
      endcase
    end
  end

endmodule : product_bcd
`default_nettype wire

// File: tb/tb_product_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_bcd
// Purpose  : Self-checking bench for product_bcd with random and directed
//            products compared against a decimal arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_bcd;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Product = '0;
  logic        Busy, Done, Neg;
  logic [19:0] Bcd;

  int n_cmp = 0;
  int n_err = 0;

  product_bcd #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Product(Product),
    .Busy(Busy), .Done(Done), .Neg(Neg), .Bcd(Bcd)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of the magnitude of a signed 16-bit value
  function automatic logic [19:0] ref_bcd(input logic [15:0] p);
    int v;
    logic [19:0] r;
    v = $signed(p);
    if (v < 0) v = -v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_neg(input logic [15:0] p);
    return ($signed(p) < 0);
  endfunction

  // Waits for Done after the accepting edge; returns cycles elapsed (0 on timeout)
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (Done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Single conversion with a one-cycle Start pulse and full result checks
  task automatic run_conv(input string tag, input logic [15:0] p);
    int cyc;
    @(negedge Clk);
    Start = 1'b1; Product = p;
    @(posedge Clk); #1;
    Start = 1'b0;
    Product = 16'($urandom);
    chk({tag, "_busy_acc"}, 32'(Busy), 32'd1);
    wait_done(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd17);
    chk({tag, "_bcd"}, 32'(Bcd), 32'(ref_bcd(p)));
    chk({tag, "_neg"}, 32'(Neg), 32'(ref_neg(p)));
    chk({tag, "_busy_done"}, 32'(Busy), 32'd1);
    @(posedge Clk); #1;
    chk({tag, "_done_clr"}, 32'(Done), 32'd0);
    chk({tag, "_busy_clr"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int cyc, ndone, first;
    logic [15:0] p;

    // Reset then idle
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (Done) ndone++;
    end
    chk("rst_bcd", 32'(Bcd), 32'h0);
    chk("rst_neg", 32'(Neg), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_nodone", 32'(ndone), 32'd0);

    // Directed values
    run_conv("neg21", 16'hFFEB);
    chk("neg21_abs", 32'(Bcd), 32'h00021);
    run_conv("p16384", 16'h4000);
    chk("p16384_abs", 32'(Bcd), 32'h16384);
    run_conv("m32768", 16'h8000);
    chk("m32768_abs", 32'(Bcd), 32'h32768);
    chk("m32768_sgn", 32'(Neg), 32'd1);
    run_conv("zero", 16'h0000);
    chk("zero_sgn", 32'(Neg), 32'd0);

    // Start during Busy is ignored and not queued
    @(negedge Clk);
    Start = 1'b1; Product = 16'h0063;
    @(posedge Clk); #1;
    Start = 1'b0;
    ndone = 0; first = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin
        @(negedge Clk);
        Start = 1'b1; Product = 16'h1234;
        @(posedge Clk); #1;
        Start = 1'b0;
      end else begin
        @(posedge Clk); #1;
      end
      if (Done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    chk("ignore_ndone", 32'(ndone), 32'd1);
    chk("ignore_lat", 32'(first), 32'd17);
    chk("ignore_bcd", 32'(Bcd), 32'h00099);
    chk("ignore_neg", 32'(Neg), 32'd0);

    // Reset mid-operation takes effect without a clock edge
    run_conv("pre_rst", 16'hFF9D);
    @(negedge Clk);
    Start = 1'b1; Product = 16'h00FF;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_bcd", 32'(Bcd), 32'h0);
    chk("midrst_neg", 32'(Neg), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (Done) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);
    run_conv("after_rst", 16'hFF01);
    chk("after_rst_abs", 32'(Bcd), 32'h00255);

    // Back-to-back with Start held high
    @(negedge Clk);
    Start = 1'b1; Product = 16'h0010;
    @(posedge Clk); #1;
    for (int n = 0; n < 3; n++) begin
      wait_done(cyc);
      chk("b2b_period", 32'(cyc), (n == 0) ? 32'd17 : 32'd18);
      chk("b2b_bcd", 32'(Bcd), 32'h00016);
    end
    @(negedge Clk);
    Start = 1'b0;
    repeat (20) @(posedge Clk);

    // Random products: valid multiplier range, then full 16-bit range
    for (int i = 0; i < 20; i++) begin
      p = 16'($signed($urandom_range(0, 32640)) - 16256);
      run_conv("rnd_mul", p);
    end
    for (int i = 0; i < 15; i++) begin
      p = 16'($urandom);
      run_conv("rnd_full", p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule : tb_product_bcd
`default_nettype wire
